// File: rtl/grn_attractor_ctrl.sv
// grn_attractor_ctrl
// ------------------
// Attractor-search sequencer for a bank of N GRN nodes. It takes each initial
// state of a programmed range in turn, loads it into the node array and runs
// a slow trajectory (s0) and a fast trajectory (s1) until the two meet. It
// then freezes s0 and steps s1 alone to measure the attractor period. One
// result record per initial state goes out over a valid/ready handshake.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    command pulse, sampled only while idle
//   init_base, num_init      first initial state / number of states to run
//   reset_nos, init_state    load strobe and per-node load value to the array
//   start_s0, start_s1       step strobes for the slow / fast trajectories
//   net_s0, net_s1           concatenated node trajectory outputs
//   res_valid, res_ready     result handshake
//   res_init, res_state      initial state and detected attractor state
//   res_steps, res_period    steps to detection and attractor length
//   res_timeout              step budget exhausted without detection
//   busy, done               not-idle flag, end-of-range pulse
module grn_attractor_ctrl #(
    parameter int N         = 8,
    parameter int CW        = 16,
    parameter int MAX_STEPS = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  init_base,
    input  logic [N:0]    num_init,
    output logic          reset_nos,
    output logic [N-1:0]  init_state,
    output logic          start_s0,
    output logic          start_s1,
    input  logic [N-1:0]  net_s0,
    input  logic [N-1:0]  net_s1,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_init,
    output logic [N-1:0]  res_state,
    output logic [CW-1:0] res_steps,
    output logic [CW-1:0] res_period,
    output logic          res_timeout,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_PERIOD = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    localparam logic [CW-1:0] LP_MAX_STEPS = CW'(MAX_STEPS);
    localparam logic [CW-1:0] LP_CNT_MAX   = {CW{1'b1}};

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == LP_CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [2:0]    r_state;
    logic [N-1:0]  r_cur;
    logic [N:0]    r_rem;
    logic [CW-1:0] r_steps;
    logic [CW-1:0] r_period;
    logic          r_first;
    logic [N-1:0]  r_det_state;
    logic          r_done;
    logic [N-1:0]  r_res_init;
    logic [N-1:0]  r_res_state;
    logic [CW-1:0] r_res_steps;
    logic [CW-1:0] r_res_period;
    logic          r_res_timeout;

    logic w_eq;
    logic w_hit;
    logic w_run_timeout;
    logic w_run_step;
    logic w_period_step;

    // Right after a load both trajectories are equal, so the first cycle of
    // RUN and of PERIOD never counts as a meeting.
    assign w_eq          = (net_s0 == net_s1);
    assign w_hit         = !r_first && w_eq;
    // A meeting in the same cycle as budget exhaustion wins over the timeout.
    // The timeout cycle itself issues no strobes, so res_steps == MAX_STEPS.
    assign w_run_timeout = (r_steps == LP_MAX_STEPS) && !w_hit;
    assign w_run_step    = (r_state == S_RUN) && !w_hit && !w_run_timeout;
    assign w_period_step = (r_state == S_PERIOD) && !w_hit;

    assign reset_nos   = (r_state == S_LOAD);
    assign init_state  = (r_state == S_LOAD) ? r_cur : '0;
    assign start_s0    = w_run_step;
    assign start_s1    = w_run_step || w_period_step;
    assign res_valid   = (r_state == S_RESULT);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign res_init    = r_res_init;
    assign res_state   = r_res_state;
    assign res_steps   = r_res_steps;
    assign res_period  = r_res_period;
    assign res_timeout = r_res_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cur         <= '0;
            r_rem         <= '0;
            r_steps       <= '0;
            r_period      <= '0;
            r_first       <= 1'b0;
            r_det_state   <= '0;
            r_done        <= 1'b0;
            r_res_init    <= '0;
            r_res_state   <= '0;
            r_res_steps   <= '0;
            r_res_period  <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (num_init != '0) begin
                            r_cur   <= init_base;
                            r_rem   <= num_init;
                            r_state <= S_LOAD;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_steps  <= '0;
                    r_period <= '0;
                    r_first  <= 1'b1;
                    r_state  <= S_RUN;
                end
                S_RUN: begin
                    if (w_hit) begin
                        // s0 is frozen from here on, so this is the state the
                        // period is measured against.
                        r_det_state <= net_s0;
                        r_first     <= 1'b1;
                        r_state     <= S_PERIOD;
                    end else if (w_run_timeout) begin
                        r_res_init    <= r_cur;
                        r_res_state   <= net_s0;
                        r_res_steps   <= r_steps;
                        r_res_period  <= '0;
                        r_res_timeout <= 1'b1;
                        r_state       <= S_RESULT;
                    end else begin
                        r_steps <= sat_inc(r_steps);
                        r_first <= 1'b0;
                    end
                end
                S_PERIOD: begin
                    if (w_hit) begin
                        r_res_init    <= r_cur;
                        r_res_state   <= r_det_state;
                        r_res_steps   <= r_steps;
                        r_res_period  <= r_period;
                        r_res_timeout <= 1'b0;
                        r_state       <= S_RESULT;
                    end else begin
                        r_period <= sat_inc(r_period);
                        r_first  <= 1'b0;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_cur <= r_cur + 1'b1;
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == (N+1)'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
